// File: rtl/phase_sched_pkg.sv
// Shared definitions for the phase scheduler: FSM state encoding and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package phase_pkg;

  localparam int XW_DEF       = 13;  // signed x/y sample width
  localparam int AW_DEF       = 19;  // signed angle width
  localparam int CALC_LAT_DEF = 20;  // phasecalc start-to-result latency
  localparam int ANGLE_FRAC   = 10;  // fractional bits of the angle (degrees x 1024)

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

endpackage

// File: rtl/phase_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after i_ptr (wrapping) wins.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
// Ports: i_req (N requests), i_ptr (search start), o_grant (one-hot), o_win (index), o_any.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_win,
  output logic                 o_any
);

  localparam int PW = $clog2(N);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;

  always_comb begin
    o_win = '0;
    o_any = 1'b0;
    w_sum = '0;
    w_idx = '0;
    // Scan from the farthest offset back to i_ptr so the closest request
    // is the last assignment and therefore the winner.
    for (int off = N - 1; off >= 0; off--) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(off);
      if (w_sum >= (PW+1)'(N)) begin
        w_sum = w_sum - (PW+1)'(N);
      end
      w_idx = w_sum[PW-1:0];
      if (i_req[w_idx]) begin
        o_win = w_idx;
        o_any = 1'b1;
      end
    end
  end

  assign o_grant = o_any ? (N'(1) << o_win) : '0;

endmodule

// File: rtl/phase_sched.sv
// Round-robin scheduler sharing one phasecalc angle unit between NCH channel requesters.
// Latency: result strobe CALC_LAT+2 cycles after the request transfer; one request per CALC_LAT+3 cycles.
// Backpressure: o_req_ready is raised only in IDLE; requests arriving while busy simply wait upstream.
// Ports: i_req_valid/i_req_x/i_req_y/o_req_ready - per-channel request handshake (channel c at [c*XW +: XW]);
//        o_pc_data_rdy/o_pc_x/o_pc_y/i_pc_angle - phasecalc start pulse, operands and result;
//        o_res_valid/o_res_ch/o_res_angle - tagged result strobe; o_busy - high outside IDLE.
module phase_sched
  import phase_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int XW       = XW_DEF,
  parameter int AW       = AW_DEF,
  parameter int CALC_LAT = CALC_LAT_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NCH-1:0]           i_req_valid,
  input  logic [NCH*XW-1:0]        i_req_x,
  input  logic [NCH*XW-1:0]        i_req_y,
  output logic [NCH-1:0]           o_req_ready,
  output logic                     o_pc_data_rdy,
  output logic [XW-1:0]            o_pc_x,
  output logic [XW-1:0]            o_pc_y,
  input  logic [AW-1:0]            i_pc_angle,
  output logic                     o_res_valid,
  output logic [$clog2(NCH)-1:0]   o_res_ch,
  output logic [AW-1:0]            o_res_angle,
  output logic                     o_busy
);

  localparam int CW   = $clog2(NCH);
  localparam int CNTW = $clog2(CALC_LAT + 1);
  localparam logic [CW-1:0]   LAST_CH  = CW'(NCH - 1);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(CALC_LAT - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_ptr;
  logic [CW-1:0]   r_ch;
  logic [CNTW-1:0] r_cnt;

  logic [NCH-1:0]  w_grant;
  logic [CW-1:0]   w_win;
  logic            w_any;
  logic            w_take;

  rr_arbiter #(.N(NCH)) u_arb (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_win   (w_win),
    .o_any   (w_any)
  );

  // Ready is forced low while reset is asserted so no transfer is ever
  // advertised during reset, even though the state already reads IDLE.
  assign o_req_ready = (r_state == ST_IDLE && i_rst_n) ? w_grant : '0;
  assign o_busy      = (r_state != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Any winner is a transfer: its ready bit is high by construction.
        if (w_any) begin
          w_take      = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr         <= '0;
      r_ch          <= '0;
      r_cnt         <= '0;
      o_pc_data_rdy <= 1'b0;
      o_pc_x        <= '0;
      o_pc_y        <= '0;
      o_res_valid   <= 1'b0;
      o_res_ch      <= '0;
      o_res_angle   <= '0;
    end else begin
      o_pc_data_rdy <= w_take;

      if (w_take) begin
        o_pc_x <= i_req_x[int'(w_win)*XW +: XW];
        o_pc_y <= i_req_y[int'(w_win)*XW +: XW];
        r_ch   <= w_win;
        r_ptr  <= (w_win == LAST_CH) ? '0 : w_win + CW'(1);
      end

      if (r_state == ST_ISSUE) begin
        r_cnt <= CNT_LOAD;
      end else if (r_state == ST_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CNTW'(1);
      end

      // Result registers load on the WAIT->CAPTURE edge so that the strobe
      // and the captured angle are both visible during the CAPTURE cycle.
      o_res_valid <= (r_state == ST_WAIT) && (r_cnt == '0);
      if (r_state == ST_WAIT && r_cnt == '0) begin
        o_res_angle <= i_pc_angle;
        o_res_ch    <= r_ch;
      end
    end
  end

endmodule

// File: tb/tb_phase_sched.sv
// Directed bench for phase_sched with a behavioural phasecalc stand-in.
// The stand-in presents the angle for exactly one cycle at the documented latency, junk otherwise.
// Requests are driven and outputs sampled one time unit after the falling clock edge.
module tb_phase_sched;

  localparam int NCH = 4;
  localparam int XW  = 13;
  localparam int AW  = 19;
  localparam int LAT = 20;
  localparam int TOL = 103;                 // 0.1 degree in angle LSBs
  localparam logic [AW-1:0] JUNK = 19'h2AAAA;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    req_valid = '0;
  logic [NCH*XW-1:0] req_x = '0;
  logic [NCH*XW-1:0] req_y = '0;
  logic [NCH-1:0]    req_ready;
  logic              pc_data_rdy;
  logic [XW-1:0]     pc_x, pc_y;
  logic [AW-1:0]     pc_angle = JUNK;
  logic              res_valid;
  logic [1:0]        res_ch;
  logic [AW-1:0]     res_angle;
  logic              busy;

  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int hs_t   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  phase_sched #(.NCH(NCH), .XW(XW), .AW(AW), .CALC_LAT(LAT)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req_valid   (req_valid),
    .i_req_x       (req_x),
    .i_req_y       (req_y),
    .o_req_ready   (req_ready),
    .o_pc_data_rdy (pc_data_rdy),
    .o_pc_x        (pc_x),
    .o_pc_y        (pc_y),
    .i_pc_angle    (pc_angle),
    .o_res_valid   (res_valid),
    .o_res_ch      (res_ch),
    .o_res_angle   (res_angle),
    .o_busy        (busy)
  );

  function automatic int sx(input logic [XW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sa(input logic [AW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int calc(input int x, input int y);
    real a;
    a = $atan2(real'(y), real'(x)) * 180.0 / 3.14159265358979 * 1024.0;
    return $rtoi(a);
  endfunction

  // phasecalc stand-in: start seen in cycle 1, angle valid only in cycle 1+LAT.
  int m_cnt = 0;
  int m_hold = 0;
  int m_val = 0;
  always @(negedge clk) begin
    if (m_hold > 0) begin
      m_hold = m_hold - 1;
      if (m_hold == 0) pc_angle = JUNK;
    end
    if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        pc_angle = m_val[AW-1:0];
        m_hold   = 1;
      end
    end
    if (pc_data_rdy) begin
      m_cnt = LAT;
      m_val = calc(sx(pc_x), sx(pc_y));
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic near(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs - exp <= TOL && exp - obs <= TOL) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, TOL);
    end
  endtask

  task automatic set_ch(input int ch, input int x, input int y);
    req_x[ch*XW +: XW] = XW'(x);
    req_y[ch*XW +: XW] = XW'(y);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"}, int'(req_ready), 0);
    check({tag, "_pc_data_rdy"}, int'(pc_data_rdy), 0);
    check({tag, "_pc_xy"}, int'({pc_x, pc_y}), 0);
    check({tag, "_res_valid"}, int'(res_valid), 0);
    check({tag, "_res_ch"}, int'(res_ch), 0);
    check({tag, "_res_angle"}, int'(res_angle), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  // Waits (bounded) for a transfer; returns at negedge+1 of the handshake cycle.
  task automatic wait_hs(input string tag, output int ch);
    ch = -1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if ((req_ready & req_valid) != '0) begin
        for (int c = 0; c < NCH; c++) if (req_ready[c]) ch = c;
        hs_t = cyc;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_onehot"}, $countones(req_ready), 1);
  endtask

  // Follows one request from the handshake cycle through CAPTURE (cycle LAT+2).
  task automatic follow(input string tag, input int ch, input int x, input int y,
                        input int set_at = -1,
                        input logic [NCH-1:0] set_mask = '0,
                        input logic [NCH-1:0] after_mask = '0);
    int rdy_n = 0, rdy_at = -1, res_n = 0, res_at = -1, grants = 0;
    for (int i = 1; i <= LAT + 2; i++) begin
      @(negedge clk);
      #1;
      if (pc_data_rdy) begin rdy_n++; rdy_at = i; end
      if (res_valid)   begin res_n++; res_at = i; end
      if (req_ready != '0) grants++;
      if (i == 1) begin
        check({tag, "_pc_x"}, sx(pc_x), x);
        check({tag, "_pc_y"}, sx(pc_y), y);
        check({tag, "_busy"}, int'(busy), 1);
      end
      if (i == LAT + 2) begin
        check({tag, "_res_ch"}, int'(res_ch), ch);
        check({tag, "_res_angle"}, sa(res_angle), calc(x, y));
        check({tag, "_pc_x_held"}, sx(pc_x), x);
      end
      if (i == set_at) req_valid = set_mask;
      else if (i == set_at + 1) req_valid = after_mask;
    end
    check({tag, "_start_cnt"}, rdy_n, 1);
    check({tag, "_start_cyc"}, rdy_at, 1);
    check({tag, "_res_cnt"}, res_n, 1);
    check({tag, "_res_cyc"}, res_at, LAT + 2);
    check({tag, "_busy_grants"}, grants, 0);
  endtask

  initial begin
    int ch, prev_t, held, cnt;
    int sw_x[4], sw_y[4], sw_e[4];

    // Reset state, with every channel requesting to expose any ungated ready.
    for (int c = 0; c < NCH; c++) set_ch(c, 1000, 0);
    req_valid = '1;
    @(negedge clk); #1;
    check_zero("reset");
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // All channels valid: grants 0,1,2,3,0 spaced 23 cycles, angle 0.
    req_valid = '1;
    prev_t = 0;
    for (int g = 0; g < 5; g++) begin
      wait_hs("rr", ch);
      check("rr_order", ch, g % NCH);
      if (g > 0) check("rr_period", hs_t - prev_t, LAT + 3);
      prev_t = hs_t;
      follow("rr", g % NCH, 1000, 0);
      check("rr_angle_zero", sa(res_angle), 0);
    end
    req_valid = '0;

    // Single request on channel 2 (third quadrant).
    set_ch(2, -1101, -2005);
    req_valid = 4'b0100;
    wait_hs("single", ch);
    check("single_ch", ch, 2);
    follow("single", 2, -1101, -2005, 1, 4'b0000, 4'b0000);
    near("single_near", sa(res_angle), -121620);
    held = sa(res_angle);
    @(negedge clk); @(negedge clk); #1;
    check("single_hold_angle", sa(res_angle), held);
    check("single_hold_valid", int'(res_valid), 0);

    // Fairness: ch0 held continuously, ch3 raised once while ch0 is busy.
    req_valid = 4'b0001;
    wait_hs("fair0", ch);
    check("fair_first", ch, 0);
    follow("fair0", 0, 1000, 0, 1, 4'b1001, 4'b1001);
    wait_hs("fair3", ch);
    check("fair_ch3", ch, 3);
    follow("fair3", 3, 1000, 0, 1, 4'b0001, 4'b0001);
    wait_hs("fair0b", ch);
    check("fair_back0", ch, 0);
    follow("fair0b", 0, 1000, 0, 1, 4'b0000, 4'b0000);

    // Bit-toggle sweep on channel 1 from 0x1800>>k patterns (0x1800 is -2048 signed).
    sw_x = '{3072, -2048, 384, 0};
    sw_y = '{1536, 768, 3072, 0};
    sw_e = '{27203, 163271, 84864, 0};
    for (int k = 0; k < 4; k++) begin
      set_ch(1, sw_x[k], sw_y[k]);
      req_valid = 4'b0010;
      wait_hs("sweep", ch);
      check("sweep_ch", ch, 1);
      follow("sweep", 1, sw_x[k], sw_y[k], 1, 4'b0000, 4'b0000);
      near("sweep_near", sa(res_angle), sw_e[k]);
    end

    // Channel 1 pulsed for one cycle while channel 0 is in flight.
    req_valid = 4'b0001;
    wait_hs("pulse", ch);
    check("pulse_ch", ch, 0);
    follow("pulse", 0, 1000, 0, 5, 4'b0010, 4'b0000);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (res_valid || req_ready != '0 || busy) cnt++;
    end
    check("pulse_quiet", cnt, 0);
    check("pulse_hold_angle", sa(res_angle), 0);

    // Reset in the middle of WAIT, then the next request is served from pointer 0.
    set_ch(2, -1101, -2005);
    req_valid = 4'b0100;
    wait_hs("abort", ch);
    check("abort_ch", ch, 2);
    for (int i = 0; i < 10; i++) @(negedge clk);
    #1;
    req_valid = '1;
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (i == 2) begin
        req_valid = '0;
        rst_n = 1'b1;
      end
      if (res_valid) cnt++;
    end
    check("abort_no_result", cnt, 0);
    req_valid = 4'b1110;
    wait_hs("after", ch);
    check("after_ptr0", ch, 1);
    follow("after", 1, 0, 0, 1, 4'b0000, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/phase_sched.md
# phase_sched

Round-robin scheduler that shares one `phasecalc` CORDIC angle unit between NCH hydrophone-channel requesters in the USBL receiver. Each channel presents a signed rectangular sample (x, y) with a valid/ready handshake. The block grants one channel at a time, drives the `phasecalc` inputs, and pulses `data_rdy`. It waits the unit's fixed latency, then returns the angle tagged with the channel index. It sits between the per-channel demodulators and the phase-difference / bearing logic.

## Interface
- NCH, 4, number of requesting channels (2..8)
- XW, 13, width of signed x/y samples
- AW, 19, width of signed angle (degrees, 10 fractional bits)
- CALC_LAT, 20, cycles from `phasecalc` data_rdy to valid angle
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- req_valid  in  NCH  per-channel request
- req_x  in  NCH*XW  per-channel signed x, channel c at [c*XW +: XW]
- req_y  in  NCH*XW  per-channel signed y, same packing
- req_ready  out  NCH  one-hot grant; transfer when req_valid[c] & req_ready[c]
- pc_data_rdy  out  1  start pulse to `phasecalc`
- pc_x, pc_y  out  XW  operands to `phasecalc`
- pc_angle  in  AW  `phasecalc` result
- res_valid  out  1  one-cycle result strobe
- res_ch  out  clog2(NCH)  channel of current result
- res_angle  out  AW  signed angle, degrees × 1024
- busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE:
  - The arbiter searches req_valid starting at rr_ptr and wrapping modulo NCH.
  - The first set bit wins. req_ready[win] = 1 combinationally; all other req_ready bits are 0.
  - On transfer: latch req_x/req_y of the winner into pc_x/pc_y, latch win into the channel register, set rr_ptr = (win+1) mod NCH, and go to ISSUE.
  - If no req_valid bit is set, stay in IDLE.
- ISSUE: pc_data_rdy = 1 for exactly one cycle; load counter = CALC_LAT−1; go to WAIT.
- WAIT: decrement the counter each cycle; at 0, go to CAPTURE.
- CAPTURE:
  - Register pc_angle into res_angle and the channel register into res_ch.
  - res_valid = 1 for one cycle; go to IDLE.
- pc_x/pc_y hold stable from ISSUE through CAPTURE.
- res_angle/res_ch hold their value until the next CAPTURE.
- req_ready is 0 in every state except IDLE. Requests raised while busy wait; no queueing inside the block.
- A requester may drop req_valid before it is granted, with no side effect.
- All requests asserted together are served in order rr_ptr, rr_ptr+1, … — no starvation.
- x = y = 0 is forwarded unchanged. The angle is whatever `phasecalc` returns; no special-casing.
- Reset (asynchronous, any state, including mid-WAIT): state = IDLE, rr_ptr = 0, counter = 0.
  - Outputs at reset: req_ready = 0, pc_data_rdy = 0, pc_x = pc_y = 0, res_valid = 0, res_ch = 0, res_angle = 0, busy = 0.
  - Any calculation in flight is discarded; no res_valid is produced for it.

## Timing
- Transfer edge E0. ISSUE (pc_data_rdy = 1) is the cycle after E0.
- res_valid is high in cycle E0 + CALC_LAT + 2. With defaults, 22 cycles after acceptance.
- A new grant is possible in the cycle after CAPTURE. Back-to-back period = CALC_LAT + 3 cycles; 23 with defaults.
- Fully synchronous outputs except req_ready, which is combinational from req_valid and the state.

## Structure
- Shared package `phase_pkg`: state encoding localparams, default XW/AW/CALC_LAT, and ANGLE_FRAC = 10.
- Sub-module `rr_arbiter`: combinational, takes req (NCH) and ptr, produces grant one-hot, win index and any. Reused elsewhere.
- `phasecalc` is instantiated at the next level up, not inside this block.

## Test plan
- Single request: channel 2, x = −1101, y = −2005.
  - Expect req_ready[2] for 1 cycle and pc_data_rdy 1 cycle later.
  - Expect res_valid 22 cycles after the transfer, res_ch = 2, res_angle ≈ −121620 (−118.77°) within `phasecalc` tolerance.
- All 4 channels held valid with x = 1000, y = 0.
  - Expect grants in order 0, 1, 2, 3, 0, each 23 cycles apart.
  - Expect res_angle ≈ 0 and res_ch following the grant order.
- Fairness: channel 0 held continuously valid; channel 3 raised once.
  - Expect channel 3 granted no later than the second grant after it is raised.
- Bit-toggle sweep, as in the `phasecalc` bench: x, y ∈ {0x1800 >> k}.
  - Expect each res_angle within 0.1° of atan2(y, x) × 1024 / (π/180).
- Reset asserted mid-WAIT.
  - Expect all outputs to go to zero immediately and no res_valid for the aborted request.
  - Expect the next request after release to be served from rr_ptr = 0.
- req_valid[1] pulsed for 1 cycle while busy.
  - Expect no grant, no result, and no disturbance to the in-flight result.
